// File: rtl/rename_unit_nw.sv
`default_nettype none
// ============================================================================
// Module      : rename_unit_nw
// Description : N-wide register rename stage. It holds a speculative map, a
//               retirement map and a circular physical free list. It handles
//               intra-group bypass, old-destination reporting, multi-port
//               commit and single-cycle flush recovery.
// Revision    : 1.0 - initial release
// ============================================================================
module rename_unit_nw #(
   parameter int WIDTH     = 2,
   parameter int COMMIT_W  = 2,
   parameter int ARCH_REGS = 32,
   parameter int PHYS_REGS = 64
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic [WIDTH-1:0]                           in_valid,
   output logic                                       in_ready,
   input  logic [WIDTH-1:0][$clog2(ARCH_REGS)-1:0]    in_rs1,
   input  logic [WIDTH-1:0][$clog2(ARCH_REGS)-1:0]    in_rs2,
   input  logic [WIDTH-1:0][$clog2(ARCH_REGS)-1:0]    in_rd,
   input  logic [WIDTH-1:0]                           in_rd_valid,
   output logic [WIDTH-1:0]                           out_valid,
   input  logic                                       out_ready,
   output logic [WIDTH-1:0][$clog2(PHYS_REGS)-1:0]    out_prs1,
   output logic [WIDTH-1:0][$clog2(PHYS_REGS)-1:0]    out_prs2,
   output logic [WIDTH-1:0][$clog2(PHYS_REGS)-1:0]    out_prd,
   output logic [WIDTH-1:0][$clog2(PHYS_REGS)-1:0]    out_old_prd,
   output logic [WIDTH-1:0]                           out_rd_valid,
   input  logic [COMMIT_W-1:0]                        commit_valid,
   input  logic [COMMIT_W-1:0][$clog2(ARCH_REGS)-1:0] commit_arch_rd,
   input  logic [COMMIT_W-1:0][$clog2(PHYS_REGS)-1:0] commit_prd,
   input  logic [COMMIT_W-1:0][$clog2(PHYS_REGS)-1:0] commit_old_prd,
   input  logic                                       flush,
   output logic [$clog2(PHYS_REGS):0]                 free_count
);

   localparam int AW       = $clog2(ARCH_REGS);
   localparam int PW       = $clog2(PHYS_REGS);
   localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
   localparam int FIDX_W   = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
   localparam int PTR_W    = PW + 1;   // free-list pointer: range 0 .. 2*FL_DEPTH-1
   localparam int CNT_W    = PW + 1;
   localparam logic [PTR_W:0] c_ptr_mod = (PTR_W+1)'(2 * FL_DEPTH);

   // Pointer arithmetic modulo 2*FL_DEPTH; the upper half acts as the wrap bit
   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                input logic [CNT_W-1:0] n);
      logic [PTR_W:0] s;
      s = {1'b0, p} + {1'b0, n};
      if (s >= c_ptr_mod) s = s - c_ptr_mod;
      return PTR_W'(s);
   endfunction

   function automatic logic [FIDX_W-1:0] ptr_idx(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] r;
      r = (p >= PTR_W'(FL_DEPTH)) ? p - PTR_W'(FL_DEPTH) : p;
      return FIDX_W'(r);
   endfunction

   function automatic logic [CNT_W-1:0] ptr_diff(input logic [PTR_W-1:0] t,
                                                 input logic [PTR_W-1:0] h);
      logic [PTR_W:0] s;
      s = {1'b0, t} - {1'b0, h};
      if (t < h) s = s + c_ptr_mod;
      return CNT_W'(s);
   endfunction

   logic [PW-1:0]             r_spec_map [ARCH_REGS];
   logic [PW-1:0]             r_ret_map  [ARCH_REGS];
   logic [PW-1:0]             r_fl       [FL_DEPTH];
   logic [PTR_W-1:0]          r_head, r_commit_head, r_tail;
   logic [CNT_W-1:0]          r_free_count;
   logic [WIDTH-1:0]          r_out_valid, r_out_rd_valid;
   logic [WIDTH-1:0][PW-1:0]  r_out_prs1, r_out_prs2, r_out_prd, r_out_old_prd;

   logic [WIDTH-1:0]             w_need;
   logic [CNT_W-1:0]             w_alloc_cnt, w_commit_cnt;
   logic [WIDTH-1:0][PW-1:0]     w_prd, w_old_prd, w_prs1, w_prs2;
   logic [PTR_W-1:0]             w_head_alloc, w_head_next, w_tail_next, w_chead_next;
   logic [PW-1:0]                w_ret_next [ARCH_REGS];
   logic [COMMIT_W-1:0][FIDX_W-1:0] w_push_idx;
   logic                         w_in_ready, w_accept;

   // Allocate from the free list in lane order and resolve sources with intra-group bypass
   always_comb begin
      logic [PTR_W-1:0] ptr;
      w_need      = '0;
      w_alloc_cnt = '0;
      w_prd       = '0;
      w_old_prd   = '0;
      w_prs1      = '0;
      w_prs2      = '0;
      ptr         = r_head;
      for (int i = 0; i < WIDTH; i++) begin
         w_need[i] = in_valid[i] && in_rd_valid[i] && (in_rd[i] != AW'(0));
         if (w_need[i]) begin
            w_prd[i]    = r_fl[ptr_idx(ptr)];
            ptr         = ptr_add(ptr, CNT_W'(1));
            w_alloc_cnt = w_alloc_cnt + CNT_W'(1);
         end
      end
      w_head_alloc = ptr;
      for (int j = 0; j < WIDTH; j++) begin
         w_prs1[j] = (in_rs1[j] == AW'(0)) ? '0 : r_spec_map[in_rs1[j]];
         w_prs2[j] = (in_rs2[j] == AW'(0)) ? '0 : r_spec_map[in_rs2[j]];
         if (w_need[j]) w_old_prd[j] = r_spec_map[in_rd[j]];
         // Ascending scan leaves the highest earlier matching lane in place
         for (int i = 0; i < j; i++) begin
            if (w_need[i] && (in_rd[i] == in_rs1[j])) w_prs1[j] = w_prd[i];
            if (w_need[i] && (in_rd[i] == in_rs2[j])) w_prs2[j] = w_prd[i];
            if (w_need[j] && w_need[i] && (in_rd[i] == in_rd[j])) w_old_prd[j] = w_prd[i];
         end
      end
   end

   // Apply commits: retirement map update (later slot wins) and free-list pushes
   always_comb begin
      logic [PTR_W-1:0] t;
      w_ret_next   = r_ret_map;
      w_push_idx   = '0;
      w_commit_cnt = '0;
      t            = r_tail;
      for (int k = 0; k < COMMIT_W; k++) begin
         if (commit_valid[k]) begin
            if (commit_arch_rd[k] != AW'(0)) w_ret_next[commit_arch_rd[k]] = commit_prd[k];
            w_push_idx[k] = ptr_idx(t);
            t             = ptr_add(t, CNT_W'(1));
            w_commit_cnt  = w_commit_cnt + CNT_W'(1);
         end
      end
      w_tail_next  = t;
      w_chead_next = ptr_add(r_commit_head, w_commit_cnt);
   end

   // Group handshake and next allocation head (flush rewinds to the commit head)
   always_comb begin
      w_in_ready = !flush && (!(|r_out_valid) || out_ready) && (r_free_count >= w_alloc_cnt);
      w_accept   = w_in_ready && (|in_valid);
      if (flush)         w_head_next = w_chead_next;
      else if (w_accept) w_head_next = w_head_alloc;
      else               w_head_next = r_head;
   end

   // State update: maps, free list, pointers and the registered output group
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ARCH_REGS; i++) begin
            r_spec_map[i] <= PW'(i);
            r_ret_map[i]  <= PW'(i);
         end
         for (int i = 0; i < FL_DEPTH; i++) r_fl[i] <= PW'(ARCH_REGS + i);
         r_head         <= '0;
         r_commit_head  <= '0;
         r_tail         <= PTR_W'(FL_DEPTH);
         r_free_count   <= CNT_W'(FL_DEPTH);
         r_out_valid    <= '0;
         r_out_rd_valid <= '0;
         r_out_prs1     <= '0;
         r_out_prs2     <= '0;
         r_out_prd      <= '0;
         r_out_old_prd  <= '0;
      end else begin
         r_ret_map <= w_ret_next;
         for (int k = 0; k < COMMIT_W; k++) begin
            if (commit_valid[k]) r_fl[w_push_idx[k]] <= commit_old_prd[k];
         end
         r_tail        <= w_tail_next;
         r_commit_head <= w_chead_next;
         r_head        <= w_head_next;
         r_free_count  <= ptr_diff(w_tail_next, w_head_next);
         if (flush) begin
            r_spec_map  <= w_ret_next;
            r_out_valid <= '0;
         end else if (w_accept) begin
            // Later lanes assign last, so the highest lane owns the final mapping
            for (int i = 0; i < WIDTH; i++) begin
               if (w_need[i]) r_spec_map[in_rd[i]] <= w_prd[i];
            end
            r_out_valid    <= in_valid;
            r_out_rd_valid <= w_need;
            r_out_prs1     <= w_prs1;
            r_out_prs2     <= w_prs2;
            r_out_prd      <= w_prd;
            r_out_old_prd  <= w_old_prd;
         end else if (out_ready) begin
            r_out_valid <= '0;
         end
      end
   end

   assign in_ready     = w_in_ready;
   assign out_valid    = r_out_valid;
   assign out_rd_valid = r_out_rd_valid;
   assign out_prs1     = r_out_prs1;
   assign out_prs2     = r_out_prs2;
   assign out_prd      = r_out_prd;
   assign out_old_prd  = r_out_old_prd;
   assign free_count   = r_free_count;

endmodule
`default_nettype wire

// File: tb/tb_rename_unit_nw.sv
`default_nettype none
// ============================================================================
// Module      : tb_rename_unit_nw
// Description : Self-checking bench for rename_unit_nw with an output
//               scoreboard and per-scenario tasks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rename_unit_nw;
   localparam int WIDTH = 2, COMMIT_W = 2, ARCH_REGS = 32, PHYS_REGS = 64;
   localparam int AW = 5, PW = 6;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [WIDTH-1:0]                 in_valid = '0, in_rd_valid = '0;
   logic                             in_ready;
   logic [WIDTH-1:0][AW-1:0]         in_rs1 = '0, in_rs2 = '0, in_rd = '0;
   logic [WIDTH-1:0]                 out_valid, out_rd_valid;
   logic                             out_ready = 1'b1;
   logic [WIDTH-1:0][PW-1:0]         out_prs1, out_prs2, out_prd, out_old_prd;
   logic [COMMIT_W-1:0]              commit_valid = '0;
   logic [COMMIT_W-1:0][AW-1:0]      commit_arch_rd = '0;
   logic [COMMIT_W-1:0][PW-1:0]      commit_prd = '0, commit_old_prd = '0;
   logic                             flush = 1'b0;
   logic [PW:0]                      free_count;

   rename_unit_nw #(.WIDTH(WIDTH), .COMMIT_W(COMMIT_W), .ARCH_REGS(ARCH_REGS),
                    .PHYS_REGS(PHYS_REGS)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_valid(in_rd_valid),
      .out_valid(out_valid), .out_ready(out_ready), .out_prs1(out_prs1),
      .out_prs2(out_prs2), .out_prd(out_prd), .out_old_prd(out_old_prd),
      .out_rd_valid(out_rd_valid), .commit_valid(commit_valid),
      .commit_arch_rd(commit_arch_rd), .commit_prd(commit_prd),
      .commit_old_prd(commit_old_prd), .flush(flush), .free_count(free_count));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [WIDTH-1:0]         valid;
      logic [WIDTH-1:0]         rdv;
      logic [WIDTH-1:0][PW-1:0] prs1;
      logic [WIDTH-1:0][PW-1:0] prs2;
      logic [WIDTH-1:0][PW-1:0] prd;
      logic [WIDTH-1:0][PW-1:0] old;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   // Scoreboard: every group taken by dispatch is compared with the oldest expectation
   always @(negedge clk) begin
      if (!reset && (|out_valid) && out_ready) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got out_valid=%b, required no output", out_valid);
         end else begin
            mon_e = exp_q.pop_front();
            n_tests++;
            if (out_valid !== mon_e.valid) begin
               n_fail++; $display("FAIL sb_valid: got %b, required %b", out_valid, mon_e.valid);
            end
            n_tests++;
            if (out_rd_valid !== mon_e.rdv) begin
               n_fail++; $display("FAIL sb_rd_valid: got %b, required %b", out_rd_valid, mon_e.rdv);
            end
            n_tests++;
            if (out_prs1 !== mon_e.prs1) begin
               n_fail++; $display("FAIL sb_prs1: got {%0d,%0d}, required {%0d,%0d}",
                  out_prs1[0], out_prs1[1], mon_e.prs1[0], mon_e.prs1[1]);
            end
            n_tests++;
            if (out_prs2 !== mon_e.prs2) begin
               n_fail++; $display("FAIL sb_prs2: got {%0d,%0d}, required {%0d,%0d}",
                  out_prs2[0], out_prs2[1], mon_e.prs2[0], mon_e.prs2[1]);
            end
            n_tests++;
            if (out_prd !== mon_e.prd) begin
               n_fail++; $display("FAIL sb_prd: got {%0d,%0d}, required {%0d,%0d}",
                  out_prd[0], out_prd[1], mon_e.prd[0], mon_e.prd[1]);
            end
            n_tests++;
            if (out_old_prd !== mon_e.old) begin
               n_fail++; $display("FAIL sb_old_prd: got {%0d,%0d}, required {%0d,%0d}",
                  out_old_prd[0], out_old_prd[1], mon_e.old[0], mon_e.old[1]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      in_valid = '0; in_rd_valid = '0;
      in_rs1 = '0; in_rs2 = '0; in_rd = '0;
   endtask

   task automatic set_lane(input int l, input int rs1, input int rs2, input int rd,
                           input bit rdv, input bit v);
      in_valid[l] = v; in_rd_valid[l] = rdv;
      in_rs1[l] = AW'(rs1); in_rs2[l] = AW'(rs2); in_rd[l] = AW'(rd);
   endtask

   task automatic push_exp(input logic [1:0] v, input logic [1:0] rdv,
                           input int s1a, input int s1b, input int s2a, input int s2b,
                           input int pa, input int pb, input int oa, input int ob);
      exp_t e;
      e.valid = v; e.rdv = rdv;
      e.prs1[0] = PW'(s1a); e.prs1[1] = PW'(s1b);
      e.prs2[0] = PW'(s2a); e.prs2[1] = PW'(s2b);
      e.prd[0]  = PW'(pa);  e.prd[1]  = PW'(pb);
      e.old[0]  = PW'(oa);  e.old[1]  = PW'(ob);
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      clear_in(); out_ready = 1'b1; commit_valid = '0; flush = 1'b0;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL sb_drained: got %0d pending groups, required 0", exp_q.size());
      end
      exp_q.delete();
      reset = 1'b1;
      #10;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_tests++;
      if (free_count !== 7'd32) begin n_fail++; $display("FAIL rst_free_count: got %0d, required 32", free_count); end
      n_tests++;
      if (out_valid !== 2'b00) begin n_fail++; $display("FAIL rst_out_valid: got %b, required 00", out_valid); end
      n_tests++;
      if ({out_prd, out_old_prd, out_prs1, out_prs2, out_rd_valid} !== '0) begin
         n_fail++; $display("FAIL rst_out_fields: got nonzero outputs, required all 0");
      end
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
      // Reset asserted in the middle of operation
      set_lane(0, 0, 0, 4, 1, 1); set_lane(1, 0, 0, 6, 1, 1);
      step();
      clear_in();
      n_tests++;
      if (free_count !== 7'd30) begin n_fail++; $display("FAIL mid_pre_free_count: got %0d, required 30", free_count); end
      reset = 1'b1;
      #1;
      n_tests++;
      if (free_count !== 7'd32) begin n_fail++; $display("FAIL mid_rst_free_count: got %0d, required 32", free_count); end
      n_tests++;
      if (out_valid !== 2'b00) begin n_fail++; $display("FAIL mid_rst_out_valid: got %b, required 00", out_valid); end
      #9;
      reset = 1'b0;
   endtask

   task automatic test_basic();
      do_reset();
      set_lane(0, 5, 0, 5, 1, 1); set_lane(1, 5, 0, 7, 1, 1);
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %b, required 1", in_ready); end
      push_exp(2'b11, 2'b11, 5, 32, 0, 0, 32, 33, 5, 7);
      step();
      clear_in();
      n_tests++;
      if (free_count !== 7'd30) begin n_fail++; $display("FAIL basic_free_count: got %0d, required 30", free_count); end
      step();
   endtask

   task automatic test_bypass();
      do_reset();
      set_lane(0, 0, 0, 3, 1, 1); set_lane(1, 0, 3, 3, 1, 1);
      push_exp(2'b11, 2'b11, 0, 0, 0, 32, 32, 33, 3, 32);
      step();
      clear_in();
      set_lane(0, 3, 3, 0, 0, 1);
      push_exp(2'b01, 2'b00, 33, 0, 33, 0, 0, 0, 0, 0);
      step();
      clear_in();
      step();
      n_tests++;
      if (free_count !== 7'd30) begin n_fail++; $display("FAIL bypass_free_count: got %0d, required 30", free_count); end
   endtask

   task automatic test_exhaust();
      do_reset();
      for (int g = 0; g < 16; g++) begin
         set_lane(0, 0, 0, 1, 1, 1); set_lane(1, 0, 0, 2, 1, 1);
         if (g == 0) push_exp(2'b11, 2'b11, 0, 0, 0, 0, 32, 33, 1, 2);
         else        push_exp(2'b11, 2'b11, 0, 0, 0, 0, 32 + 2*g, 33 + 2*g, 30 + 2*g, 31 + 2*g);
         step();
      end
      n_tests++;
      if (free_count !== 7'd0) begin n_fail++; $display("FAIL empty_free_count: got %0d, required 0", free_count); end
      n_tests++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL empty_in_ready: got %b, required 0", in_ready); end
      commit_valid = 2'b01; commit_arch_rd[0] = 5'd1; commit_prd[0] = 6'd32; commit_old_prd[0] = 6'd5;
      step();
      commit_valid = '0;
      #1;
      n_tests++;
      if (free_count !== 7'd1) begin n_fail++; $display("FAIL freed_free_count: got %0d, required 1", free_count); end
      n_tests++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL two_alloc_blocked: got in_ready=%b, required 0", in_ready); end
      n_tests++;
      if (out_valid !== 2'b00) begin n_fail++; $display("FAIL blocked_out_valid: got %b, required 00", out_valid); end
      set_lane(0, 0, 0, 9, 1, 1); set_lane(1, 0, 0, 4, 0, 1);
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL one_alloc_ready: got %b, required 1", in_ready); end
      push_exp(2'b11, 2'b01, 0, 0, 0, 0, 5, 0, 9, 0);
      step();
      clear_in();
      n_tests++;
      if (free_count !== 7'd0) begin n_fail++; $display("FAIL reuse_free_count: got %0d, required 0", free_count); end
      step();
   endtask

   task automatic test_flush();
      do_reset();
      set_lane(0, 0, 0, 1, 1, 1); set_lane(1, 0, 0, 2, 1, 1);
      push_exp(2'b11, 2'b11, 0, 0, 0, 0, 32, 33, 1, 2);
      step();
      set_lane(0, 0, 0, 3, 1, 1); set_lane(1, 0, 0, 4, 1, 1);
      push_exp(2'b11, 2'b11, 0, 0, 0, 0, 34, 35, 3, 4);
      step();
      set_lane(0, 0, 0, 7, 1, 1); set_lane(1, 0, 0, 0, 0, 0);
      flush = 1'b1;
      #1;
      n_tests++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b, required 0", in_ready); end
      step();
      flush = 1'b0;
      clear_in();
      n_tests++;
      if (free_count !== 7'd32) begin n_fail++; $display("FAIL flush_free_count: got %0d, required 32", free_count); end
      n_tests++;
      if (out_valid !== 2'b00) begin n_fail++; $display("FAIL flush_out_valid: got %b, required 00", out_valid); end
      set_lane(0, 1, 0, 1, 1, 1); set_lane(1, 3, 0, 0, 0, 1);
      push_exp(2'b11, 2'b01, 1, 3, 0, 0, 32, 0, 1, 0);
      step();
      clear_in();
      step();
   endtask

   task automatic test_flush_commit();
      do_reset();
      set_lane(0, 0, 0, 5, 1, 1);
      push_exp(2'b01, 2'b01, 0, 0, 0, 0, 32, 0, 5, 0);
      step();
      clear_in();
      flush = 1'b1;
      commit_valid = 2'b01; commit_arch_rd[0] = 5'd5; commit_prd[0] = 6'd32; commit_old_prd[0] = 6'd5;
      step();
      flush = 1'b0; commit_valid = '0;
      n_tests++;
      if (free_count !== 7'd32) begin n_fail++; $display("FAIL fc_free_count: got %0d, required 32", free_count); end
      set_lane(0, 5, 0, 6, 1, 1);
      push_exp(2'b01, 2'b01, 32, 0, 0, 0, 33, 0, 6, 0);
      step();
      clear_in();
      step();
   endtask

   task automatic test_back_to_back_stall();
      do_reset();
      out_ready = 1'b0;
      set_lane(0, 0, 0, 2, 1, 1);
      push_exp(2'b01, 2'b01, 0, 0, 0, 0, 32, 0, 2, 0);
      step();
      set_lane(0, 0, 0, 3, 1, 1);
      for (int c = 0; c < 3; c++) begin
         #1;
         n_tests++;
         if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b, required 0", in_ready); end
         n_tests++;
         if (out_valid !== 2'b01 || out_prd !== {6'd0, 6'd32} || out_old_prd !== {6'd0, 6'd2}) begin
            n_fail++; $display("FAIL stall_hold: got valid=%b prd0=%0d old0=%0d, required 01/32/2",
               out_valid, out_prd[0], out_old_prd[0]);
         end
         n_tests++;
         if (free_count !== 7'd31) begin n_fail++; $display("FAIL stall_free_count: got %0d, required 31", free_count); end
         step();
      end
      out_ready = 1'b1;
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b, required 1", in_ready); end
      push_exp(2'b01, 2'b01, 0, 0, 0, 0, 33, 0, 3, 0);
      step();
      set_lane(0, 2, 0, 0, 1, 1);
      push_exp(2'b01, 2'b00, 32, 0, 0, 0, 0, 0, 0, 0);
      step();
      clear_in();
      step();
      n_tests++;
      if (free_count !== 7'd30) begin n_fail++; $display("FAIL b2b_free_count: got %0d, required 30", free_count); end
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_bypass();
      test_exhaust();
      test_flush();
      test_flush_commit();
      test_back_to_back_stall();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL sb_final_drained: got %0d pending groups, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
